// File: rtl/dmem_write_buffer.sv
// Posted-write buffer between the CPU data port and data memory.
// Stores queue in a DEPTH-entry FIFO and drain over a req/ack handshake;
// loads are forwarded from pending stores (youngest match wins).
// Optional store coalescing into the tail-most entry: define WBUF_COALESCE_EN.
module dmem_write_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 16,
  parameter int DW    = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [AW-1:0]                d_addr,
  input  logic [DW-1:0]                d_dataout,
  input  logic                         d_we,
  output logic [DW-1:0]                d_datain,
  output logic                         stall,
  output logic [AW-1:0]                mem_raddr,
  input  logic [DW-1:0]                mem_rdata,
  output logic [AW-1:0]                mem_waddr,
  output logic [DW-1:0]                mem_wdata,
  output logic                         mem_wreq,
  input  logic                         mem_wack,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef enum logic {IDLE, REQ} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q [DEPTH];
  logic [DW-1:0]   data_q [DEPTH];
  logic [PW-1:0]   head_q, tail_q, last_idx, fwd_idx;
  logic [CW-1:0]   count_q;
  logic            full, coal, push, pop, load_head;
  logic [DW-1:0]   head_data;

  assign full     = (count_q == CW'(DEPTH));
  assign last_idx = tail_q - PW'(1);

`ifdef WBUF_COALESCE_EN
  // The in-flight head must not change under an outstanding request.
  assign coal = d_we && (count_q != '0) && (addr_q[last_idx] == d_addr) &&
                !((state_q == REQ) && (count_q == CW'(1)));
`else
  assign coal = 1'b0;
`endif

  // Full check uses the registered count only, so no path from mem_wack.
  assign stall = d_we & full & ~coal;
  assign push  = d_we & ~full & ~coal;
  assign pop   = (state_q == REQ) & mem_wack;

  // A coalesce into the head while IDLE lands on the same edge the head is
  // captured for draining, so the new data must bypass the entry array.
  assign head_data = (coal && (last_idx == head_q)) ? d_dataout : data_q[head_q];

  assign mem_raddr = d_addr;
  assign mem_wreq  = (state_q == REQ);
  assign count     = count_q;
  assign empty     = (count_q == '0);

  // Drain FSM next-state: IDLE captures the head whenever entries exist.
  always_comb begin
    state_d   = state_q;
    load_head = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          load_head = 1'b1;
          state_d   = REQ;
        end
      end
      REQ: begin
        if (mem_wack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state, pointers, occupancy and the drain request registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      mem_waddr <= '0;
      mem_wdata <= '0;
    end else begin
      state_q <= state_d;
      if (push) tail_q <= tail_q + PW'(1);
      if (pop)  head_q <= head_q + PW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
      if (load_head) begin
        mem_waddr <= addr_q[head_q];
        mem_wdata <= head_data;
      end
    end
  end

  // Entry storage: validity comes from head/count, so no reset is needed.
  always_ff @(posedge clock) begin
    if (push) begin
      addr_q[tail_q] <= d_addr;
      data_q[tail_q] <= d_dataout;
    end else if (coal) begin
      data_q[last_idx] <= d_dataout;
    end
  end

  // Load forwarding: walk oldest to youngest so the youngest match wins.
  always_comb begin
    d_datain = mem_rdata;
    fwd_idx  = head_q;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = head_q + PW'(i);
      if ((CW'(i) < count_q) && (addr_q[fwd_idx] == d_addr))
        d_datain = data_q[fwd_idx];
    end
  end

endmodule
